// File: rtl/tight_acc_matmul_pkg.sv
// tight_acc_matmul_pkg: opcodes, FSM states and command field positions
package tight_acc_matmul_pkg;
  localparam logic [5:0] OP_CFG    = 6'd0;
  localparam logic [5:0] OP_LOAD_A = 6'd1;
  localparam logic [5:0] OP_LOAD_B = 6'd2;
  localparam logic [5:0] OP_START  = 6'd3;
  localparam logic [5:0] OP_STATUS = 6'd4;
  localparam logic [63:0] ERR_WORD = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int CFG_N_LSB = 0;
  localparam int CFG_N_MSB = 7;
  localparam int CFG_SGN   = 8;
  localparam int CFG_ACC   = 9;
  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, RESP1} state_t;
endpackage

// File: rtl/tight_acc_matmul_mac.sv
// tight_acc_mac: serial multiply-accumulate; sum is the value the accumulator takes this cycle
module tight_acc_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 34
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              sgn,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  init,
  output logic [ACC_W-1:0]  sum
);
  logic [ACC_W-1:0] acc, ea, eb, prod;
  assign ea = {{(ACC_W-DATA_W){sgn & a[DATA_W-1]}}, a};
  assign eb = {{(ACC_W-DATA_W){sgn & b[DATA_W-1]}}, b};
  assign prod = ea * eb;
  // clr starts a new dot product from init instead of the running total
  assign sum = (clr ? init : acc) + prod;
  always_ff @(posedge clk) begin
    if (!rst_n) acc <= '0;
    else if (en) acc <= sum;
  end
endmodule

// File: rtl/tight_acc_matmul.sv
// tight_acc_matmul: command-driven matrix multiply with A/B/C register arrays,
// one serial MAC and a row-major response drain with backpressure
module tight_acc_matmul
  import tight_acc_matmul_pkg::*;
#(
  parameter int N_MAX  = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 2*DATA_W+$clog2(N_MAX)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_val,
  output logic        busy,
  input  logic [5:0]  cmd_opcode,
  input  logic [63:0] cmd_config_data,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [63:0] resp_data
);
  localparam int IW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  if (ACC_W > 64) begin : g_acc_chk
    $error("ACC_W must not exceed 64");
  end
  state_t state;
  logic [7:0] n, cfg_n;
  logic sgn, accm, a_full, b_full;
  logic take, cfg_ok, last_i, last_j, last_k, hs, unused_bits;
  logic [IW-1:0] ar, ac, br, bc, i, j, k, nm1, ni, nj;
  logic [DATA_W-1:0] a_m [N_MAX][N_MAX];
  logic [DATA_W-1:0] b_m [N_MAX][N_MAX];
  logic [ACC_W-1:0] c_m [N_MAX][N_MAX];
  logic [ACC_W-1:0] mac_sum;
  function automatic logic [63:0] ext64(input logic [ACC_W-1:0] x, input logic s);
    logic signed [ACC_W-1:0] sx;
    logic signed [63:0] r;
    sx = x;
    r = 64'(sx);
    return s ? r : 64'(x);
  endfunction
  assign take = cmd_val && !busy;
  assign cfg_n = cmd_config_data[CFG_N_MSB:CFG_N_LSB];
  assign cfg_ok = cfg_n != 8'd0 && cfg_n <= 8'(N_MAX);
  assign nm1 = IW'(n - 8'd1);
  assign last_i = i == nm1;
  assign last_j = j == nm1;
  assign last_k = k == nm1;
  assign hs = resp_val && resp_rdy;
  assign nj = last_j ? '0 : j + 1'b1;
  assign ni = last_j ? (last_i ? '0 : i + 1'b1) : i;
  assign unused_bits = ^cmd_config_data;
  tight_acc_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == COMPUTE),
    .clr   (k == '0),
    .sgn   (sgn),
    .a     (a_m[i][k]),
    .b     (b_m[k][j]),
    .init  (accm ? c_m[i][j] : '0),
    .sum   (mac_sum)
  );
  // operand arrays keep their contents across reset
  always_ff @(posedge clk) begin
    if (rst_n && take && cmd_opcode == OP_LOAD_A) a_m[ar][ac] <= cmd_config_data[DATA_W-1:0];
    if (rst_n && take && cmd_opcode == OP_LOAD_B) b_m[br][bc] <= cmd_config_data[DATA_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      resp_val <= 1'b0;
      resp_data <= '0;
      n <= 8'(N_MAX);
      sgn <= 1'b0;
      accm <= 1'b0;
      {ar, ac, br, bc, i, j, k} <= '0;
      {a_full, b_full} <= 2'b00;
      for (int r = 0; r < N_MAX; r++)
        for (int q = 0; q < N_MAX; q++)
          c_m[r][q] <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          if (cmd_opcode == OP_CFG && cfg_ok) begin
            n <= cfg_n;
            sgn <= cmd_config_data[CFG_SGN];
            accm <= cmd_config_data[CFG_ACC];
            {ar, ac, br, bc} <= '0;
            {a_full, b_full} <= 2'b00;
            for (int r = 0; r < N_MAX; r++)
              for (int q = 0; q < N_MAX; q++)
                c_m[r][q] <= '0;
          end else if (cmd_opcode == OP_CFG) begin
            state <= RESP1;
            busy <= 1'b1;
            resp_val <= 1'b1;
            resp_data <= ERR_WORD;
          end else if (cmd_opcode == OP_LOAD_A) begin
            ac <= (ac == nm1) ? '0 : ac + 1'b1;
            if (ac == nm1) ar <= (ar == nm1) ? '0 : ar + 1'b1;
            if (ac == nm1 && ar == nm1) a_full <= 1'b1;
          end else if (cmd_opcode == OP_LOAD_B) begin
            bc <= (bc == nm1) ? '0 : bc + 1'b1;
            if (bc == nm1) br <= (br == nm1) ? '0 : br + 1'b1;
            if (bc == nm1 && br == nm1) b_full <= 1'b1;
          end else if (cmd_opcode == OP_START) begin
            state <= COMPUTE;
            busy <= 1'b1;
            {i, j, k} <= '0;
          end else if (cmd_opcode == OP_STATUS) begin
            state <= RESP1;
            busy <= 1'b1;
            resp_val <= 1'b1;
            resp_data <= {47'b0, accm, sgn, n, a_full, b_full, 5'b0};
          end
        end
        COMPUTE: begin
          k <= last_k ? '0 : k + 1'b1;
          if (last_k) begin
            c_m[i][j] <= mac_sum;
            j <= nj;
            i <= ni;
          end
          // C[0][0] is only being written right now when n is 1
          if (last_k && last_j && last_i) begin
            state <= DRAIN;
            resp_val <= 1'b1;
            resp_data <= ext64((n == 8'd1) ? mac_sum : c_m[0][0], sgn);
          end
        end
        DRAIN: if (hs) begin
          j <= nj;
          i <= ni;
          state <= (last_i && last_j) ? IDLE : DRAIN;
          busy <= !(last_i && last_j);
          resp_val <= !(last_i && last_j);
          resp_data <= (last_i && last_j) ? '0 : ext64(c_m[ni][nj], sgn);
        end
        RESP1: if (hs) begin
          state <= IDLE;
          busy <= 1'b0;
          resp_val <= 1'b0;
          resp_data <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tight_acc_matmul.sv
// tb_tight_acc_matmul: directed command sequences with hand-computed responses
module tb_tight_acc_matmul;
  logic clk = 1'b0;
  logic rst_n, cmd_val, busy, resp_val, resp_rdy;
  logic [5:0] cmd_opcode;
  logic [63:0] cmd_config_data, resp_data;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  tight_acc_matmul dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_val         (cmd_val),
    .busy            (busy),
    .cmd_opcode      (cmd_opcode),
    .cmd_config_data (cmd_config_data),
    .resp_val        (resp_val),
    .resp_rdy        (resp_rdy),
    .resp_data       (resp_data)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [5:0] op, input logic [63:0] d);
    int t = 0;
    while (busy && t < 200) begin
      step();
      t++;
    end
    cmd_val = 1'b1;
    cmd_opcode = op;
    cmd_config_data = d;
    step();
    cmd_val = 1'b0;
  endtask
  task automatic get_resp(input string tag, input logic [63:0] exp);
    int t = 0;
    resp_rdy = 1'b1;
    while (!resp_val && t < 200) begin
      step();
      t++;
    end
    chk({tag, "_val"}, 64'(resp_val), 64'd1);
    chk(tag, resp_data, exp);
    step();
  endtask
  task automatic cfg(input int nn, input bit s, input bit a);
    send(6'd0, 64'(nn) | (64'(s) << 8) | (64'(a) << 9));
  endtask
  task automatic load_ab(input logic [15:0] av[4], input logic [15:0] bv[4]);
    for (int q = 0; q < 4; q++) send(6'd1, 64'(av[q]));
    for (int q = 0; q < 4; q++) send(6'd2, 64'(bv[q]));
  endtask
  initial begin
    logic [15:0] a1[4] = '{16'd1, 16'd2, 16'd3, 16'd4};
    logic [15:0] id[4] = '{16'd1, 16'd0, 16'd0, 16'd1};
    rst_n = 1'b0;
    cmd_val = 1'b0;
    cmd_opcode = '0;
    cmd_config_data = '0;
    resp_rdy = 1'b1;
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_val", 64'(resp_val), 64'd0);
    chk("rst_data", resp_data, 64'd0);
    rst_n = 1'b1;
    send(6'd4, 64'd0);
    get_resp("rst_status", 64'h200);
    // identity B: result equals A, streamed back-to-back
    cfg(2, 0, 0);
    load_ab(a1, id);
    send(6'd3, 64'd0);
    for (int c = 0; c < 8; c++) begin
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_noval", 64'(resp_val), 64'd0);
      step();
    end
    for (int e = 0; e < 4; e++) begin
      chk("t1_val", 64'(resp_val), 64'd1);
      chk("t1_data", resp_data, 64'(e + 1));
      step();
    end
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_idle_val", 64'(resp_val), 64'd0);
    // signed vs unsigned sign extension
    cfg(1, 1, 0);
    send(6'd1, 64'hFFFF);
    send(6'd2, 64'd3);
    send(6'd3, 64'd0);
    get_resp("t2_signed", 64'hFFFF_FFFF_FFFF_FFFD);
    cfg(1, 0, 0);
    send(6'd1, 64'hFFFF);
    send(6'd2, 64'd3);
    send(6'd3, 64'd0);
    get_resp("t2_unsigned", 64'h2_FFFD);
    // full-size worst-case magnitude, then pointer wrap
    cfg(4, 0, 0);
    for (int q = 0; q < 16; q++) send(6'd1, 64'hFFFF);
    for (int q = 0; q < 16; q++) send(6'd2, 64'hFFFF);
    send(6'd4, 64'd0);
    get_resp("t3_status", 64'h260);
    send(6'd3, 64'd0);
    for (int e = 0; e < 16; e++) get_resp("t3_max", 64'h3_FFF8_0004);
    send(6'd1, 64'd1);
    send(6'd3, 64'd0);
    for (int e = 0; e < 16; e++) get_resp("t3_wrap", (e < 4) ? 64'h2_FFFB_0002 : 64'h3_FFF8_0004);
    // backpressure on element 2, command during drain dropped
    cfg(2, 0, 0);
    load_ab(a1, id);
    send(6'd3, 64'd0);
    get_resp("t4_e1", 64'd1);
    resp_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("t4_hold_val", 64'(resp_val), 64'd1);
      chk("t4_hold_data", resp_data, 64'd2);
      cmd_val = 1'b1;
      cmd_opcode = 6'd0;
      cmd_config_data = 64'd1;
      step();
    end
    cmd_val = 1'b0;
    get_resp("t4_e2", 64'd2);
    get_resp("t4_e3", 64'd3);
    get_resp("t4_e4", 64'd4);
    chk("t4_idle", 64'(busy), 64'd0);
    send(6'd4, 64'd0);
    get_resp("t4_status", 64'h160);
    // accumulate across two STARTs, then bad CFG
    cfg(2, 0, 1);
    load_ab(a1, id);
    send(6'd3, 64'd0);
    for (int e = 0; e < 4; e++) get_resp("t5_first", 64'(e + 1));
    send(6'd3, 64'd0);
    for (int e = 0; e < 4; e++) get_resp("t5_second", 64'(2 * (e + 1)));
    cfg(9, 0, 0);
    get_resp("t5_err", 64'hFFFF_FFFF_FFFF_FFFF);
    send(6'd4, 64'd0);
    get_resp("t5_status", 64'h1_0160);
    // reset in the middle of compute
    cfg(2, 0, 0);
    send(6'd3, 64'd0);
    step();
    step();
    chk("t6_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    step();
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_val", 64'(resp_val), 64'd0);
    chk("t6_data", resp_data, 64'd0);
    rst_n = 1'b1;
    send(6'd4, 64'd0);
    get_resp("t6_status", 64'h200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
